// File: rtl/dbus_arbiter_pkg.sv
// Shared AHB3-Lite constants and data-bus request types for the data-bus arbiter.
package p_hardisc;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_B = 3'b000;
   localparam logic [2:0] HSIZE_H = 3'b001;
   localparam logic [2:0] HSIZE_W = 3'b010;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_SEC  = 1'b1
   } dbus_owner;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [1:0]  size;
      logic [31:0] wdata;
   } dbus_req;

   // Requesters only issue B/H/W, so the HSIZE MSB is always zero.
   function automatic logic [2:0] to_hsize(input logic [1:0] size);
      return {1'b0, size};
   endfunction

endpackage

// File: rtl/dbus_arbiter_fair_cnt.sv
// Saturating count of consecutive core grants taken while the secondary waits.
module dbus_fair_cnt #(
   parameter int unsigned HOLD_MAX = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/dbus_arbiter.sv
// Two-requester AHB3-Lite data-bus arbiter: core priority, starvation bound for the
// secondary, pipelined address/data phases with the address phase frozen under wait states.
module dbus_arbiter
   import p_hardisc::*;
#(
   parameter int unsigned HOLD_MAX = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic        s_clk_i,
   input  logic        s_reset_i,
   input  logic        s_c_req_i,
   input  logic [31:0] s_c_addr_i,
   input  logic        s_c_write_i,
   input  logic [1:0]  s_c_size_i,
   input  logic [31:0] s_c_wdata_i,
   output logic        s_c_gnt_o,
   output logic        s_c_rvalid_o,
   input  logic        s_s_req_i,
   input  logic [31:0] s_s_addr_i,
   input  logic        s_s_write_i,
   input  logic [1:0]  s_s_size_i,
   input  logic [31:0] s_s_wdata_i,
   output logic        s_s_gnt_o,
   output logic        s_s_rvalid_o,
   output logic [31:0] s_rdata_o,
   output logic        s_err_o,
   output logic [31:0] s_haddr_o,
   output logic        s_hwrite_o,
   output logic [2:0]  s_hsize_o,
   output logic [1:0]  s_htrans_o,
   output logic [31:0] s_hwdata_o,
   input  logic [31:0] s_hrdata_i,
   input  logic        s_hready_i,
   input  logic        s_hresp_i
);

   // Handshake: a requester holds req (and its fields) high until it sees gnt in the
   // same cycle; exactly one rvalid follows per grant, carrying rdata/err.

   logic      lock_q, lock_d;
   dbus_owner lock_own_q, lock_own_d;
   dbus_req   lock_req_q, lock_req_d;

   logic        dp_vld_q, dp_vld_d;
   dbus_owner   dp_own_q, dp_own_d;
   logic [31:0] dp_wdata_q, dp_wdata_d;

   dbus_req   c_req, s_req, ap_req;
   dbus_owner ap_own;
   logic      ap_vld;
   logic      err_first;
   logic      gnt;
   logic      cmpl;
   logic      cnt_sat, cnt_inc, cnt_clr;

   assign c_req = '{addr: s_c_addr_i, write: s_c_write_i, size: s_c_size_i, wdata: s_c_wdata_i};
   assign s_req = '{addr: s_s_addr_i, write: s_s_write_i, size: s_s_size_i, wdata: s_s_wdata_i};

   // First cycle of a two-cycle ERROR response: no new unlocked address phase may start.
   assign err_first = dp_vld_q & s_hresp_i & ~s_hready_i;

   always_comb begin
      ap_vld = 1'b0;
      ap_own = OWN_CORE;
      ap_req = c_req;
      if (lock_q) begin
         ap_vld = 1'b1;
         ap_own = lock_own_q;
         ap_req = lock_req_q;
      end else if (!err_first) begin
         if (s_c_req_i && !(cnt_sat && s_s_req_i)) begin
            ap_vld = 1'b1;
         end else if (s_s_req_i) begin
            ap_vld = 1'b1;
            ap_own = OWN_SEC;
            ap_req = s_req;
         end
      end
   end

   assign gnt  = ap_vld & s_hready_i;
   assign cmpl = dp_vld_q & s_hready_i;

   assign s_htrans_o = ap_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign s_haddr_o  = ap_vld ? ap_req.addr : 32'h0;
   assign s_hwrite_o = ap_vld ? ap_req.write : 1'b0;
   assign s_hsize_o  = ap_vld ? to_hsize(ap_req.size) : HSIZE_B;
   assign s_hwdata_o = dp_vld_q ? dp_wdata_q : 32'h0;

   assign s_c_gnt_o    = gnt & (ap_own == OWN_CORE);
   assign s_s_gnt_o    = gnt & (ap_own == OWN_SEC);
   assign s_c_rvalid_o = cmpl & (dp_own_q == OWN_CORE);
   assign s_s_rvalid_o = cmpl & (dp_own_q == OWN_SEC);
   assign s_rdata_o    = s_hrdata_i;
   assign s_err_o      = cmpl & s_hresp_i;

   // An address phase stalled by HREADY keeps its owner and fields until accepted.
   always_comb begin
      lock_d     = ap_vld & ~s_hready_i;
      lock_own_d = lock_own_q;
      lock_req_d = lock_req_q;
      if (ap_vld && !s_hready_i) begin
         lock_own_d = ap_own;
         lock_req_d = ap_req;
      end
   end

   always_comb begin
      dp_vld_d   = dp_vld_q;
      dp_own_d   = dp_own_q;
      dp_wdata_d = dp_wdata_q;
      if (gnt) begin
         dp_vld_d   = 1'b1;
         dp_own_d   = ap_own;
         dp_wdata_d = ap_req.wdata;
      end else if (cmpl) begin
         dp_vld_d = 1'b0;
      end
   end

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         lock_q     <= 1'b0;
         lock_own_q <= OWN_CORE;
         lock_req_q <= '0;
         dp_vld_q   <= 1'b0;
         dp_own_q   <= OWN_CORE;
         dp_wdata_q <= 32'h0;
      end else begin
         lock_q     <= lock_d;
         lock_own_q <= lock_own_d;
         lock_req_q <= lock_req_d;
         dp_vld_q   <= dp_vld_d;
         dp_own_q   <= dp_own_d;
         dp_wdata_q <= dp_wdata_d;
      end
   end

   assign cnt_inc = gnt & (ap_own == OWN_CORE) & s_s_req_i;
   assign cnt_clr = ~s_s_req_i | (gnt & (ap_own == OWN_SEC));

   dbus_fair_cnt #(
      .HOLD_MAX (HOLD_MAX),
      .CNT_W    (CNT_W)
   ) u_fair_cnt (
      .clk_i   (s_clk_i),
      .reset_i (s_reset_i),
      .inc_i   (cnt_inc),
      .clr_i   (cnt_clr),
      .sat_o   (cnt_sat)
   );

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: directed scenarios plus randomized traffic,
// each cycle compared against a transaction-level model of the arbitration rules.
module tb_dbus_arbiter;
   import p_hardisc::*;

   localparam int HOLD_MAX = 8;
   localparam int CNT_W    = 8;
   localparam int OBS_W    = 75;

   logic        s_clk_i = 1'b0;
   logic        s_reset_i;
   logic        s_c_req_i, s_c_write_i, s_s_req_i, s_s_write_i;
   logic [31:0] s_c_addr_i, s_c_wdata_i, s_s_addr_i, s_s_wdata_i;
   logic [1:0]  s_c_size_i, s_s_size_i;
   logic        s_c_gnt_o, s_c_rvalid_o, s_s_gnt_o, s_s_rvalid_o, s_err_o, s_hwrite_o;
   logic [31:0] s_rdata_o, s_haddr_o, s_hwdata_o, s_hrdata_i;
   logic [2:0]  s_hsize_o;
   logic [1:0]  s_htrans_o;
   logic        s_hready_i, s_hresp_i;

   always #5 s_clk_i = ~s_clk_i;

   dbus_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
      .s_clk_i(s_clk_i), .s_reset_i(s_reset_i),
      .s_c_req_i(s_c_req_i), .s_c_addr_i(s_c_addr_i), .s_c_write_i(s_c_write_i),
      .s_c_size_i(s_c_size_i), .s_c_wdata_i(s_c_wdata_i),
      .s_c_gnt_o(s_c_gnt_o), .s_c_rvalid_o(s_c_rvalid_o),
      .s_s_req_i(s_s_req_i), .s_s_addr_i(s_s_addr_i), .s_s_write_i(s_s_write_i),
      .s_s_size_i(s_s_size_i), .s_s_wdata_i(s_s_wdata_i),
      .s_s_gnt_o(s_s_gnt_o), .s_s_rvalid_o(s_s_rvalid_o),
      .s_rdata_o(s_rdata_o), .s_err_o(s_err_o),
      .s_haddr_o(s_haddr_o), .s_hwrite_o(s_hwrite_o), .s_hsize_o(s_hsize_o),
      .s_htrans_o(s_htrans_o), .s_hwdata_o(s_hwdata_o),
      .s_hrdata_i(s_hrdata_i), .s_hready_i(s_hready_i), .s_hresp_i(s_hresp_i)
   );

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- reference model (transaction level) ----------------
   typedef struct packed {
      logic        own;   // 0 core, 1 secondary
      logic [31:0] addr;
      logic        write;
      logic [1:0]  size;
      logic [31:0] wdata;
   } txn_t;

   txn_t exp_q[$];        // transfers whose data phase is outstanding
   logic m_stall_v;
   txn_t m_stall;
   int   m_cnt;
   logic e_win_v;
   txn_t e_win;
   logic e_done;

   task automatic model_reset();
      exp_q.delete();
      m_stall_v = 1'b0;
      m_stall   = '0;
      m_cnt     = 0;
   endtask

   function automatic txn_t cur_txn(input logic own);
      txn_t t;
      if (!own) t = '{own: 1'b0, addr: s_c_addr_i, write: s_c_write_i, size: s_c_size_i, wdata: s_c_wdata_i};
      else      t = '{own: 1'b1, addr: s_s_addr_i, write: s_s_write_i, size: s_s_size_i, wdata: s_s_wdata_i};
      return t;
   endfunction

   task automatic model_eval(output logic [OBS_W-1:0] e);
      logic ef, cg, sg, cr, sr;
      txn_t hd;
      hd = '0;
      if (exp_q.size() != 0) hd = exp_q[0];
      ef = (exp_q.size() != 0) && s_hresp_i && !s_hready_i;
      e_win_v = 1'b0;
      e_win   = cur_txn(1'b0);
      if (m_stall_v) begin
         e_win_v = 1'b1;
         e_win   = m_stall;
      end else if (!ef) begin
         if (s_c_req_i && !(m_cnt == HOLD_MAX && s_s_req_i)) e_win_v = 1'b1;
         else if (s_s_req_i) begin
            e_win_v = 1'b1;
            e_win   = cur_txn(1'b1);
         end
      end
      cg = e_win_v && s_hready_i && !e_win.own;
      sg = e_win_v && s_hready_i && e_win.own;
      e_done = (exp_q.size() != 0) && s_hready_i;
      cr = e_done && !hd.own;
      sr = e_done && hd.own;
      e = {e_win_v ? HTRANS_NONSEQ : HTRANS_IDLE,
           e_win_v ? e_win.addr : 32'h0,
           e_win_v ? e_win.write : 1'b0,
           e_win_v ? {1'b0, e_win.size} : 3'b000,
           (exp_q.size() != 0) ? hd.wdata : 32'h0,
           cg, sg, cr, sr, e_done && s_hresp_i};
   endtask

   task automatic model_advance();
      if (exp_q.size() != 0 && s_hready_i) void'(exp_q.pop_front());
      if (e_win_v && s_hready_i) exp_q.push_back(e_win);
      m_stall_v = e_win_v && !s_hready_i;
      if (m_stall_v) m_stall = e_win;
      if (!s_s_req_i) m_cnt = 0;
      else if (e_win_v && s_hready_i) m_cnt = e_win.own ? 0 : ((m_cnt < HOLD_MAX) ? m_cnt + 1 : HOLD_MAX);
   endtask

   function automatic logic [OBS_W-1:0] dut_obs();
      return {s_htrans_o, s_haddr_o, s_hwrite_o, s_hsize_o, s_hwdata_o,
              s_c_gnt_o, s_s_gnt_o, s_c_rvalid_o, s_s_rvalid_o, s_err_o};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge s_clk_i);
      #1;
   endtask

   task automatic set_core(input logic req, input logic [31:0] addr, input logic wr,
                           input logic [1:0] sz, input logic [31:0] wd);
      s_c_req_i = req; s_c_addr_i = addr; s_c_write_i = wr; s_c_size_i = sz; s_c_wdata_i = wd;
   endtask

   task automatic set_sec(input logic req, input logic [31:0] addr, input logic wr,
                          input logic [1:0] sz, input logic [31:0] wd);
      s_s_req_i = req; s_s_addr_i = addr; s_s_write_i = wr; s_s_size_i = sz; s_s_wdata_i = wd;
   endtask

   task automatic set_bus(input logic rdy, input logic resp, input logic [31:0] rd);
      s_hready_i = rdy; s_hresp_i = resp; s_hrdata_i = rd;
   endtask

   task automatic apply_reset(input int n);
      s_reset_i = 1'b1;
      repeat (n) next_cycle();
      model_reset();
      s_reset_i = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [OBS_W-1:0] e, o;
      set_core(0, 0, 0, 0, 0); set_sec(0, 0, 0, 0, 0); set_bus(1, 0, 0);
      apply_reset(2);
      #3;
      model_eval(e); o = dut_obs();
      n_cmp++;
      if (o !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", o); end
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL reset_model: got %h want %h", o, e); end
      model_advance(); next_cycle();
   endtask

   task automatic test_core_read();
      logic [OBS_W-1:0] e, o;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin set_core(1, 32'h0000_1000, 0, 2, 0); set_bus(1, 0, 0); end
         else begin set_core(0, 0, 0, 0, 0); set_bus(1, 0, 32'hDEAD_BEEF); end
         set_sec(0, 0, 0, 0, 0);
         #3;
         model_eval(e); o = dut_obs();
         n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL core_read c%0d: got %h want %h", k, o, e); end
         n_cmp++;
         if (k == 0 && !(s_c_gnt_o === 1'b1 && s_htrans_o === HTRANS_NONSEQ && s_haddr_o === 32'h0000_1000)) begin
            n_err++; $display("FAIL core_read_gnt: gnt=%b htrans=%b want 1/10", s_c_gnt_o, s_htrans_o);
         end
         if (k == 1 && !(s_c_rvalid_o === 1'b1 && s_rdata_o === 32'hDEAD_BEEF && s_err_o === 1'b0)) begin
            n_err++; $display("FAIL core_read_rvalid: rv=%b rdata=%h err=%b want 1/deadbeef/0", s_c_rvalid_o, s_rdata_o, s_err_o);
         end
         model_advance(); next_cycle();
      end
   endtask

   task automatic test_addr_wait();
      logic [OBS_W-1:0] e, o;
      for (int k = 0; k < 5; k++) begin
         if (k == 0) set_core(1, 32'h2000_0004, 1, 2, 32'h1234_5678);
         else        set_core(0, 0, 0, 0, 0);
         set_sec((k == 1), 32'h9000_0000, 0, 0, 0);
         set_bus((k >= 3), 0, 0);
         #3;
         model_eval(e); o = dut_obs();
         n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL addr_wait c%0d: got %h want %h", k, o, e); end
         n_cmp++;
         if (k < 3 && !(s_htrans_o === HTRANS_NONSEQ && s_haddr_o === 32'h2000_0004 && s_c_gnt_o === 1'b0)) begin
            n_err++; $display("FAIL addr_wait_hold c%0d: htrans=%b haddr=%h gnt=%b", k, s_htrans_o, s_haddr_o, s_c_gnt_o);
         end
         if (k == 3 && s_c_gnt_o !== 1'b1) begin
            n_err++; $display("FAIL addr_wait_gnt: gnt=%b want 1", s_c_gnt_o);
         end
         if (k == 4 && !(s_hwdata_o === 32'h1234_5678 && s_c_rvalid_o === 1'b1)) begin
            n_err++; $display("FAIL addr_wait_wdata: hwdata=%h rv=%b want 12345678/1", s_hwdata_o, s_c_rvalid_o);
         end
         model_advance(); next_cycle();
      end
   endtask

   task automatic test_starvation();
      logic [OBS_W-1:0] e, o;
      for (int k = 0; k < 3 * (HOLD_MAX + 1); k++) begin
         set_core(1, $urandom(), 0, 2, $urandom());
         set_sec(1, $urandom(), 1, 2, $urandom());
         set_bus(1, 0, $urandom());
         #3;
         model_eval(e); o = dut_obs();
         n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL starve c%0d: got %h want %h", k, o, e); end
         n_cmp++;
         if ({s_c_gnt_o, s_s_gnt_o} !== ((k % (HOLD_MAX + 1) == HOLD_MAX) ? 2'b01 : 2'b10)) begin
            n_err++; $display("FAIL starve_pattern c%0d: cg/sg=%b%b", k, s_c_gnt_o, s_s_gnt_o);
         end
         model_advance(); next_cycle();
      end
   endtask

   task automatic test_back_to_back();
      logic [OBS_W-1:0] e, o;
      logic [31:0] wd;
      wd = $urandom();
      for (int k = 0; k < 3; k++) begin
         set_core((k == 0), 32'h0000_3000, 0, 2, 0);
         set_sec((k == 1), 32'h4000_0008, 1, 2, wd);
         set_bus(1, 0, 32'hA5A5_0000 + k);
         #3;
         model_eval(e); o = dut_obs();
         n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL b2b c%0d: got %h want %h", k, o, e); end
         n_cmp++;
         if (k == 1 && !(s_c_rvalid_o === 1'b1 && s_s_gnt_o === 1'b1)) begin
            n_err++; $display("FAIL b2b_overlap: c_rv=%b s_gnt=%b want 1/1", s_c_rvalid_o, s_s_gnt_o);
         end
         if (k == 2 && !(s_s_rvalid_o === 1'b1 && s_hwdata_o === wd)) begin
            n_err++; $display("FAIL b2b_sec_done: s_rv=%b hwdata=%h want 1/%h", s_s_rvalid_o, s_hwdata_o, wd);
         end
         model_advance(); next_cycle();
      end
   endtask

   task automatic test_error();
      logic [OBS_W-1:0] e, o;
      for (int k = 0; k < 4; k++) begin
         set_core((k == 0), 32'h0000_5000, 0, 2, 0);
         set_sec((k == 1 || k == 2), 32'h6000_0010, 1, 1, 32'h0BAD_F00D);
         case (k)
            0:       set_bus(1, 0, 0);
            1:       set_bus(0, 1, 0);
            2:       set_bus(1, 1, 0);
            default: set_bus(1, 0, 0);
         endcase
         #3;
         model_eval(e); o = dut_obs();
         n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL error c%0d: got %h want %h", k, o, e); end
         n_cmp++;
         if (k == 1 && !(s_htrans_o === HTRANS_IDLE && s_s_gnt_o === 1'b0 && s_c_rvalid_o === 1'b0)) begin
            n_err++; $display("FAIL error_suppress: htrans=%b s_gnt=%b c_rv=%b", s_htrans_o, s_s_gnt_o, s_c_rvalid_o);
         end
         if (k == 2 && !(s_c_rvalid_o === 1'b1 && s_err_o === 1'b1 && s_s_gnt_o === 1'b1)) begin
            n_err++; $display("FAIL error_report: c_rv=%b err=%b s_gnt=%b want 1/1/1", s_c_rvalid_o, s_err_o, s_s_gnt_o);
         end
         if (k == 3 && !(s_s_rvalid_o === 1'b1 && s_err_o === 1'b0)) begin
            n_err++; $display("FAIL error_after: s_rv=%b err=%b want 1/0", s_s_rvalid_o, s_err_o);
         end
         model_advance(); next_cycle();
      end
   endtask

   task automatic test_reset_locked();
      logic [OBS_W-1:0] e, o;
      // Build up core grants against a waiting secondary, then stall with a data phase open.
      for (int k = 0; k < 6; k++) begin
         set_core(1, $urandom(), 0, 2, $urandom());
         set_sec(1, $urandom(), 0, 2, $urandom());
         set_bus((k < 5), 0, $urandom());
         #3;
         model_eval(e); o = dut_obs();
         n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL rst_lock_pre c%0d: got %h want %h", k, o, e); end
         model_advance(); next_cycle();
      end
      apply_reset(1);
      for (int k = 0; k < HOLD_MAX + 1; k++) begin
         set_core(1, $urandom(), 0, 2, $urandom());
         set_sec(1, $urandom(), 0, 2, $urandom());
         set_bus(1, 0, $urandom());
         #3;
         model_eval(e); o = dut_obs();
         n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL rst_lock_post c%0d: got %h want %h", k, o, e); end
         n_cmp++;
         if (k == 0 && !(s_c_rvalid_o === 1'b0 && s_s_rvalid_o === 1'b0 && s_hwdata_o === 32'h0)) begin
            n_err++; $display("FAIL rst_lock_abandon: rv=%b%b hwdata=%h want 00/0", s_c_rvalid_o, s_s_rvalid_o, s_hwdata_o);
         end
         if (s_s_gnt_o !== (k == HOLD_MAX)) begin
            n_err++; $display("FAIL rst_lock_cnt c%0d: s_gnt=%b want %b", k, s_s_gnt_o, (k == HOLD_MAX));
         end
         model_advance(); next_cycle();
      end
      // Lock an address phase, then reset with requests dropped: bus must go IDLE.
      set_core(1, 32'h7000_0000, 1, 2, 32'h1111_2222); set_sec(0, 0, 0, 0, 0); set_bus(0, 0, 0);
      #3;
      model_eval(e); o = dut_obs();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL rst_lock_stall: got %h want %h", o, e); end
      model_advance(); next_cycle();
      set_core(0, 0, 0, 0, 0);
      apply_reset(1);
      set_bus(1, 0, 0);
      #3;
      n_cmp++;
      if (!(s_htrans_o === HTRANS_IDLE && s_c_rvalid_o === 1'b0 && s_s_rvalid_o === 1'b0 && s_c_gnt_o === 1'b0)) begin
         n_err++; $display("FAIL rst_lock_idle: htrans=%b rv=%b%b gnt=%b want 00/00/0", s_htrans_o, s_c_rvalid_o, s_s_rvalid_o, s_c_gnt_o);
      end
      model_eval(e); model_advance(); next_cycle();
   endtask

   task automatic test_random();
      logic [OBS_W-1:0] e, o;
      logic c_pend, s_pend, sl_act, sl_err, sl_ph;
      int   sl_wait;
      txn_t c_t, s_t;
      c_pend = 0; s_pend = 0; sl_act = 0; sl_err = 0; sl_ph = 0; sl_wait = 0;
      c_t = '0; s_t = '0;
      set_core(0, 0, 0, 0, 0); set_sec(0, 0, 0, 0, 0); set_bus(1, 0, 0);
      apply_reset(1);
      for (int k = 0; k < 600; k++) begin
         if (!c_pend && $urandom_range(0, 1) == 1) begin
            c_pend = 1; c_t = '{own: 1'b0, addr: $urandom(), write: 1'($urandom_range(0, 1)),
                                size: 2'($urandom_range(0, 2)), wdata: $urandom()};
         end
         if (!s_pend && $urandom_range(0, 2) == 0) begin
            s_pend = 1; s_t = '{own: 1'b1, addr: $urandom(), write: 1'($urandom_range(0, 1)),
                                size: 2'($urandom_range(0, 2)), wdata: $urandom()};
         end
         set_core(c_pend, c_t.addr, c_t.write, c_t.size, c_t.wdata);
         set_sec(s_pend, s_t.addr, s_t.write, s_t.size, s_t.wdata);
         if (exp_q.size() != 0) begin
            if (!sl_act) begin
               sl_act = 1; sl_wait = $urandom_range(0, 2); sl_err = ($urandom_range(0, 4) == 0); sl_ph = 0;
            end
            if (sl_wait > 0)            set_bus(0, 0, $urandom());
            else if (sl_err && !sl_ph)  set_bus(0, 1, $urandom());
            else                        set_bus(1, sl_err, $urandom());
         end else begin
            set_bus(($urandom_range(0, 3) != 0), 0, $urandom());
         end
         #3;
         model_eval(e); o = dut_obs();
         n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL random c%0d: got %h want %h", k, o, e); end
         if (e_done) begin
            n_cmp++;
            if (s_rdata_o !== s_hrdata_i) begin
               n_err++; $display("FAIL random_rdata c%0d: got %h want %h", k, s_rdata_o, s_hrdata_i);
            end
         end
         if (s_c_gnt_o) c_pend = 0;
         if (s_s_gnt_o) s_pend = 0;
         if (sl_act) begin
            if (sl_wait > 0)            sl_wait--;
            else if (sl_err && !sl_ph)  sl_ph = 1;
            else                        sl_act = 0;
         end
         model_advance(); next_cycle();
      end
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      s_reset_i = 1'b1;
      set_core(0, 0, 0, 0, 0); set_sec(0, 0, 0, 0, 0); set_bus(1, 0, 0);
      model_reset();
      next_cycle();
      test_reset();
      test_core_read();
      test_addr_wait();
      test_starvation();
      test_back_to_back();
      test_error();
      test_reset_locked();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
